// File: rtl/stump_io_pkg.sv
// Shared definitions for the Stump memory-mapped I/O block: register offsets,
// flag bit positions, reset values and the STATUS word layout.
package stump_io_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned CTRL_W = 2;

    localparam logic [3:0] OFF_TXDATA  = 4'd0;
    localparam logic [3:0] OFF_STATUS  = 4'd1;
    localparam logic [3:0] OFF_RXDATA  = 4'd2;
    localparam logic [3:0] OFF_TIMER   = 4'd3;
    localparam logic [3:0] OFF_COMPARE = 4'd4;
    localparam logic [3:0] OFF_CTRL    = 4'd5;

    localparam int unsigned ST_RX_OVR    = 3;
    localparam int unsigned ST_TMR_MATCH = 4;
    localparam int unsigned ST_TX_OVF    = 5;

    localparam int unsigned CTRL_TMR_IE = 0;
    localparam int unsigned CTRL_RX_IE  = 1;

    localparam logic [DATA_W-1:0] COMPARE_RST = 16'hFFFF;

    typedef struct packed {
        logic [2:0]       rsvd_hi;
        logic [CNT_W-1:0] tx_count;
        logic [1:0]       rsvd_lo;
        logic             tx_ovf;
        logic             tmr_match;
        logic             rx_ovr;
        logic             rx_full;
        logic             tx_empty;
        logic             tx_full;
    } status_t;

endpackage

// File: rtl/stump_io_fifo.sv
// Transmit FIFO: pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter.
module stump_io_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push on a full FIFO is only taken when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + CW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/stump_io.sv
// Stump memory-mapped I/O: address decode, TX FIFO port, RX byte register,
// free-running timer with compare, level interrupt and combinational read mux.
module stump_io
    import stump_io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              mem_wen,
    input  logic              mem_ren,
    output logic              sel,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_strobe,
    output logic              irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]        offset;
    logic              wr;
    logic              rd;
    logic              wr_tx;
    logic              wr_status;
    logic              wr_timer;
    logic              wr_compare;
    logic              wr_ctrl;
    logic              rd_rx;

    logic              tx_full;
    logic              tx_empty;
    logic              tx_pop;
    logic              tx_drop;
    logic [CW-1:0]     tx_count;

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_full;
    logic              rx_ovr;
    logic              tmr_match;
    logic              tx_ovf;
    logic [DATA_W-1:0] timer;
    logic [DATA_W-1:0] compare;
    logic [CTRL_W-1:0] ctrl;

    status_t           status;
    logic [DATA_W-1:0] rdata;

    // Decode; a simultaneous read and write counts as a write only.
    assign offset     = address[3:0];
    assign sel        = (address[15:4] == BASE_ADDR[15:4]);
    assign wr         = sel && mem_wen;
    assign rd         = sel && mem_ren && !mem_wen;
    assign wr_tx      = wr && (offset == OFF_TXDATA);
    assign wr_status  = wr && (offset == OFF_STATUS);
    assign wr_timer   = wr && (offset == OFF_TIMER);
    assign wr_compare = wr && (offset == OFF_COMPARE);
    assign wr_ctrl    = wr && (offset == OFF_CTRL);
    assign rd_rx      = rd && (offset == OFF_RXDATA);

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_drop  = wr_tx && tx_full && !tx_pop;

    stump_io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .pop   (tx_pop),
        .din   (data_in[BYTE_W-1:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Flags: write-1-to-clear, with a coincident set taking priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_byte   <= '0;
            rx_full   <= 1'b0;
            rx_ovr    <= 1'b0;
            tmr_match <= 1'b0;
            tx_ovf    <= 1'b0;
            timer     <= '0;
            compare   <= COMPARE_RST;
            ctrl      <= '0;
        end else begin
            if (rx_strobe) rx_byte <= rx_data;
            rx_full   <= rx_strobe || (rx_full && !rd_rx);
            rx_ovr    <= (rx_ovr && !(wr_status && data_in[ST_RX_OVR]))
                         || (rx_strobe && rx_full && !rd_rx);
            tmr_match <= (tmr_match && !(wr_status && data_in[ST_TMR_MATCH]))
                         || (timer == compare);
            tx_ovf    <= (tx_ovf && !(wr_status && data_in[ST_TX_OVF])) || tx_drop;
            timer     <= wr_timer ? data_in : timer + DATA_W'(1);
            if (wr_compare) compare <= data_in;
            if (wr_ctrl)    ctrl    <= data_in[CTRL_W-1:0];
        end
    end

    assign irq = (tmr_match && ctrl[CTRL_TMR_IE]) || (rx_full && ctrl[CTRL_RX_IE]);

    always_comb begin
        status           = '0;
        status.tx_count  = CNT_W'(tx_count);
        status.tx_ovf    = tx_ovf;
        status.tmr_match = tmr_match;
        status.rx_ovr    = rx_ovr;
        status.rx_full   = rx_full;
        status.tx_empty  = tx_empty;
        status.tx_full   = tx_full;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OFF_STATUS:  rdata = status;
            OFF_RXDATA:  rdata = {8'h00, rx_byte};
            OFF_TIMER:   rdata = timer;
            OFF_COMPARE: rdata = compare;
            OFF_CTRL:    rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
            default:     rdata = '0;
        endcase
    end

    assign data_out = sel ? rdata : '0;

endmodule

// File: tb/tb_stump_io.sv
// Bench for stump_io: directed scenarios plus a randomized run against a
// queue-based behavioural model of the peripheral.
module tb_stump_io;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    logic        sel;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strobe = 1'b0;
    logic        irq;

    int checks = 0;
    int passes = 0;

    // Behavioural model state
    logic [7:0]  m_q[$];
    logic        m_ovf, m_match, m_rx_full, m_rx_ovr;
    logic [7:0]  m_rx_byte;
    logic [15:0] m_timer, m_cmp;
    logic [1:0]  m_ctrl;

    stump_io dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .sel       (sel),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0; m_match = 0; m_rx_full = 0; m_rx_ovr = 0;
        m_rx_byte = 8'h00; m_timer = 16'h0000; m_cmp = 16'hFFFF; m_ctrl = 2'b00;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit          s, w, r, clr_ovr, clr_match, clr_ovf, match_now;
        int          off;
        logic [15:0] nxt_timer;
        s   = (address[15:4] == 12'hFF0);
        w   = s && mem_wen;
        r   = s && mem_ren && !mem_wen;
        off = int'(address[3:0]);
        clr_ovr   = w && off == 1 && data_in[3];
        clr_match = w && off == 1 && data_in[4];
        clr_ovf   = w && off == 1 && data_in[5];
        match_now = (m_timer == m_cmp);
        m_match   = (m_match && !clr_match) || match_now;
        m_ovf     = m_ovf && !clr_ovf;
        if (m_q.size() > 0 && tx_ready) void'(m_q.pop_front());
        if (w && off == 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(data_in[7:0]);
            else m_ovf = 1;
        end
        m_rx_ovr = m_rx_ovr && !clr_ovr;
        if (rx_strobe) begin
            if (m_rx_full && !(r && off == 2)) m_rx_ovr = 1;
            m_rx_byte = rx_data;
            m_rx_full = 1;
        end else if (r && off == 2) begin
            m_rx_full = 0;
        end
        nxt_timer = m_timer + 16'd1;
        if (w && off == 3) nxt_timer = data_in;
        m_timer = nxt_timer;
        if (w && off == 4) m_cmp = data_in;
        if (w && off == 5) m_ctrl = data_in[1:0];
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int n;
        n = m_q.size();
        if (a[15:4] != 12'hFF0) return 16'h0000;
        case (a[3:0])
            4'd1: return {3'b000, 5'(n), 2'b00, m_ovf, m_match, m_rx_ovr, m_rx_full,
                          n == 0, n == DEPTH};
            4'd2: return {8'h00, m_rx_byte};
            4'd3: return m_timer;
            4'd4: return m_cmp;
            4'd5: return {14'h0000, m_ctrl};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a; data_in = d; mem_wen = 1'b1; mem_ren = 1'b0;
        tick();
        mem_wen = 1'b0;
    endtask

    task automatic rd_start(input logic [15:0] a);
        address = a; mem_ren = 1'b1; mem_wen = 1'b0;
        #1;
    endtask

    task automatic rd_end();
        tick();
        mem_ren = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_data = b; rx_strobe = 1'b1;
        tick();
        rx_strobe = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) wr(16'hFF00, 16'(8'hA0 + i));
        repeat (4) tick();
        rst = 1'b0;
        #2;
        checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else passes++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passes++;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passes++;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        rd_start(16'hFF03);
        checks++; if (data_out !== 16'h0000) $display("FAIL reset_timer got %h want 0000", data_out); else passes++;
        rd_end();
        rd_start(16'hFF04);
        checks++; if (data_out !== 16'hFFFF) $display("FAIL reset_compare got %h want ffff", data_out); else passes++;
        rd_end();
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0002) $display("FAIL reset_status got %h want 0002", data_out); else passes++;
        rd_end();
    endtask

    task automatic test_tx_fill();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(16'hFF00, 16'(8'h41 + i));
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0821) $display("FAIL tx_fill_status got %h want 0821", data_out); else passes++;
        rd_end();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i))
                $display("FAIL tx_fill_order[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
            else passes++;
            tick();
        end
        tx_ready = 1'b0;
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0022 || tx_valid !== 1'b0)
            $display("FAIL tx_fill_empty got status=%h v=%b want 0022 v=0", data_out, tx_valid); else passes++;
        rd_end();
        wr(16'hFF01, 16'h0020);
    endtask

    task automatic test_tx_full_pushpop();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(16'hFF00, 16'(8'h60 + i));
        tx_ready = 1'b1;
        wr(16'hFF00, 16'h0050);
        tx_ready = 1'b0;
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0801) $display("FAIL tx_pushpop_status got %h want 0801", data_out); else passes++;
        rd_end();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp;
            exp = (i == 7) ? 8'h50 : 8'(8'h61 + i);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp)
                $display("FAIL tx_pushpop_order[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp);
            else passes++;
            tick();
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) $display("FAIL tx_pushpop_drained got %b want 0", tx_valid); else passes++;
    endtask

    task automatic test_rx();
        strobe(8'h12);
        strobe(8'h34);
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h000E) $display("FAIL rx_ovr_status got %h want 000e", data_out); else passes++;
        rd_end();
        rd_start(16'hFF02);
        checks++; if (data_out !== 16'h0034) $display("FAIL rx_data got %h want 0034", data_out); else passes++;
        rd_end();
        wr(16'hFF01, 16'h0008);
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0002) $display("FAIL rx_w1c_status got %h want 0002", data_out); else passes++;
        rd_end();
        strobe(8'h56);
        rx_data = 8'h78; rx_strobe = 1'b1;
        rd_start(16'hFF02);
        checks++; if (data_out !== 16'h0056) $display("FAIL rx_coincident_read got %h want 0056", data_out); else passes++;
        rd_end();
        rx_strobe = 1'b0;
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0006) $display("FAIL rx_no_ovr_status got %h want 0006", data_out); else passes++;
        rd_end();
        rd_start(16'hFF02);
        checks++; if (data_out !== 16'h0078) $display("FAIL rx_new_byte got %h want 0078", data_out); else passes++;
        rd_end();
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0002) $display("FAIL rx_cleared_status got %h want 0002", data_out); else passes++;
        rd_end();
    endtask

    task automatic test_timer();
        wr(16'hFF04, 16'h0001);
        wr(16'hFF03, 16'hFFFE);
        wr(16'hFF01, 16'h0010);
        wr(16'hFF05, 16'h0001);
        checks++; if (irq !== 1'b0) $display("FAIL tmr_pre0 irq got %b want 0", irq); else passes++;
        tick();
        checks++; if (irq !== 1'b0) $display("FAIL tmr_pre1 irq got %b want 0", irq); else passes++;
        tick();
        checks++; if (irq !== 1'b1) $display("FAIL tmr_match irq got %b want 1", irq); else passes++;
        rd_start(16'hFF03);
        checks++; if (data_out !== 16'h0002) $display("FAIL tmr_count got %h want 0002", data_out); else passes++;
        rd_end();
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0012) $display("FAIL tmr_status got %h want 0012", data_out); else passes++;
        rd_end();
        wr(16'hFF01, 16'h0010);
        checks++; if (irq !== 1'b0) $display("FAIL tmr_w1c irq got %b want 0", irq); else passes++;
        wr(16'hFF03, 16'h0100);
        wr(16'hFF04, 16'h0102);
        tick();
        wr(16'hFF01, 16'h0010);
        checks++; if (irq !== 1'b1) $display("FAIL tmr_set_wins irq got %b want 1", irq); else passes++;
        wr(16'hFF01, 16'h0010);
        checks++; if (irq !== 1'b0) $display("FAIL tmr_second_w1c irq got %b want 0", irq); else passes++;
        wr(16'hFF05, 16'h0000);
    endtask

    task automatic test_decode();
        rd_start(16'hFEFF);
        checks++; if (sel !== 1'b0 || data_out !== 16'h0000)
            $display("FAIL decode_outside got sel=%b d=%h want sel=0 d=0000", sel, data_out); else passes++;
        rd_end();
        rd_start(16'hFF0A);
        checks++; if (sel !== 1'b1 || data_out !== 16'h0000)
            $display("FAIL decode_unused got sel=%b d=%h want sel=1 d=0000", sel, data_out); else passes++;
        rd_end();
        wr(16'hFE00, 16'h0077);
        checks++; if (tx_valid !== 1'b0) $display("FAIL decode_write_outside tx_valid got %b want 0", tx_valid); else passes++;
        strobe(8'h9A);
        address = 16'hFF02; data_in = 16'h0000; mem_wen = 1'b1; mem_ren = 1'b1;
        tick();
        mem_wen = 1'b0; mem_ren = 1'b0;
        rd_start(16'hFF01);
        checks++; if (data_out !== 16'h0006) $display("FAIL decode_rw_keeps_rx got %h want 0006", data_out); else passes++;
        rd_end();
        rd_start(16'hFF02);
        rd_end();
    endtask

    task automatic test_random();
        logic [7:0]  exp_tx;
        logic [15:0] exp_do;
        logic        exp_irq;
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) address = 16'($urandom);
            else address = 16'hFF00 | 16'($urandom_range(0, 15));
            data_in   = 16'($urandom);
            mem_wen   = ($urandom_range(0, 3) == 0);
            mem_ren   = ($urandom_range(0, 2) == 0);
            tx_ready  = ($urandom_range(0, 2) == 0);
            rx_strobe = ($urandom_range(0, 4) == 0);
            rx_data   = 8'($urandom);
            #1;
            exp_do  = model_read(address);
            exp_tx  = (m_q.size() > 0) ? m_q[0] : 8'h00;
            exp_irq = (m_match && m_ctrl[0]) || (m_rx_full && m_ctrl[1]);
            checks++; if (sel !== (address[15:4] == 12'hFF0))
                $display("FAIL rnd_sel[%0d] addr=%h got %b", n, address, sel); else passes++;
            checks++; if (data_out !== exp_do)
                $display("FAIL rnd_data_out[%0d] addr=%h got %h want %h", n, address, data_out, exp_do); else passes++;
            checks++; if (tx_valid !== (m_q.size() > 0))
                $display("FAIL rnd_tx_valid[%0d] got %b want %b", n, tx_valid, m_q.size() > 0); else passes++;
            checks++; if (tx_data !== exp_tx)
                $display("FAIL rnd_tx_data[%0d] got %h want %h", n, tx_data, exp_tx); else passes++;
            checks++; if (irq !== exp_irq)
                $display("FAIL rnd_irq[%0d] got %b want %b", n, irq, exp_irq); else passes++;
            tick();
        end
        mem_wen = 1'b0; mem_ren = 1'b0; rx_strobe = 1'b0; tx_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        test_reset();
        test_tx_fill();
        test_tx_full_pushpop();
        test_rx();
        test_timer();
        test_decode();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
